// File: rtl/r_ingress_pkg.sv
// r_ingress_pkg: shared router ingress types, header layout and helpers.
package r_ingress_pkg;
    localparam int DATA_W = 8;
    localparam int NPORT = 3;
    localparam int LEN_W = 6;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB = 2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;
    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_e;
    function automatic logic [1:0] hdr_addr(input logic [DATA_W-1:0] b);
        return b[HDR_ADDR_LSB +: 2];
    endfunction
    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] b);
        return b[HDR_LEN_LSB +: LEN_W];
    endfunction
endpackage

// File: rtl/r_ingress_outreg.sv
// r_ingress_outreg: one-entry output register feeding the FIFOs, drains when the target is not full.
module r_ingress_outreg
    import r_ingress_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              load_valid_i,
    input  logic              load_hdr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [1:0]        load_addr_i,
    input  logic [NPORT-1:0]  fifo_full_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic [NPORT-1:0]  write_enb_o,
    output logic              lfd_state_o
);
    logic              valid_q, valid_d, hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        addr_q, addr_d;
    logic [3:0]        full_ext;

    assign full_ext = {1'b0, fifo_full_i};
    assign stall_o = valid_q && full_ext[addr_q];
    assign data_out_o = data_q;
    assign lfd_state_o = valid_q && hdr_q;
    assign write_enb_o = (valid_q && addr_q != ADDR_INVALID) ? (NPORT'(1) << addr_q) : '0;

    // A load on the draining edge replaces the entry, so there is no bubble.
    always_comb begin
        valid_d = load_i ? load_valid_i : stall_o;
        hdr_d = load_i ? load_hdr_i : hdr_q;
        data_d = load_i ? load_data_i : data_q;
        addr_d = load_i ? load_addr_i : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            hdr_q <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            valid_q <= valid_d;
            hdr_q <= hdr_d;
            data_q <= data_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/r_ingress_ctrl.sv
// r_ingress_ctrl: decodes packet headers, steers bytes into per-port FIFOs and checks trailing parity.
module r_ingress_ctrl
    import r_ingress_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pkt_valid_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [NPORT-1:0]  fifo_full_i,
    input  logic [NPORT-1:0]  fifo_empty_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic [NPORT-1:0]  write_enb_o,
    output logic              lfd_state_o,
    output logic              parity_done_o,
    output logic              err_o
);
    state_e            state_q;
    logic [LEN_W-1:0]  cnt_q, in_len;
    logic [DATA_W-1:0] par_q;
    logic [1:0]        addr_q, in_addr;
    logic              err_q, pdone_q, stall, acc, hdr_ok;
    logic [3:0]        empty_ext;

    assign in_addr = hdr_addr(data_in_i);
    assign in_len = hdr_len(data_in_i);
    assign hdr_ok = in_addr != ADDR_INVALID;
    assign empty_ext = {1'b1, fifo_empty_i};
    assign acc = pkt_valid_i && !busy_o;
    assign err_o = err_q;
    assign parity_done_o = pdone_q;

    // A new packet may only start into a FIFO that has fully drained.
    always_comb begin
        busy_o = (state_q == DROP) ? 1'b0 :
                 (state_q == IDLE) ? (stall || (pkt_valid_i && hdr_ok && !empty_ext[in_addr])) :
                 stall;
    end

    r_ingress_outreg u_outreg (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (acc),
        .load_valid_i (state_q == IDLE ? hdr_ok : state_q != DROP),
        .load_hdr_i   (state_q == IDLE),
        .load_data_i  (data_in_i),
        .load_addr_i  (state_q == IDLE ? in_addr : addr_q),
        .fifo_full_i  (fifo_full_i),
        .stall_o      (stall),
        .data_out_o   (data_out_o),
        .write_enb_o  (write_enb_o),
        .lfd_state_o  (lfd_state_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q <= '0;
            par_q <= '0;
            addr_q <= '0;
            err_q <= 1'b0;
            pdone_q <= 1'b0;
        end else begin
            pdone_q <= 1'b0;
            if (acc) begin
                case (state_q)
                    IDLE: begin
                        addr_q <= in_addr;
                        cnt_q <= in_len;
                        par_q <= data_in_i;
                        err_q <= 1'b0;
                        state_q <= !hdr_ok ? DROP : (in_len == '0) ? PARITY : PAYLOAD;
                    end
                    PAYLOAD: begin
                        par_q <= par_q ^ data_in_i;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) state_q <= PARITY;
                    end
                    PARITY: begin
                        err_q <= data_in_i != par_q;
                        pdone_q <= 1'b1;
                        state_q <= IDLE;
                    end
                    DROP: begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == '0) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_r_ingress_ctrl.sv
// tb_r_ingress_ctrl: randomized packet bench; expected FIFO contents are built from the packet format.
module tb_r_ingress_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, pkt_valid = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic [2:0] fifo_full = '0, fifo_empty = '1, write_enb;
    logic       busy, lfd_state, parity_done, err;
    int         tests = 0, fails = 0, pd_cnt = 0, busy_cnt = 0;
    bit         gap_en = 0, run = 0;
    logic [8:0] got_q[3][$];
    logic [8:0] exp_q[3][$];

    always #5 clk = ~clk;

    r_ingress_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pkt_valid_i   (pkt_valid),
        .data_in_i     (data_in),
        .fifo_full_i   (fifo_full),
        .fifo_empty_i  (fifo_empty),
        .busy_o        (busy),
        .data_out_o    (data_out),
        .write_enb_o   (write_enb),
        .lfd_state_o   (lfd_state),
        .parity_done_o (parity_done),
        .err_o         (err)
    );

    // Records what each FIFO will write on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++)
                if (write_enb[i] && !fifo_full[i]) got_q[i].push_back({lfd_state, data_out});
            if (parity_done) pd_cnt++;
            if (pkt_valid && busy) busy_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_sb();
        for (int i = 0; i < 3; i++) begin
            got_q[i].delete();
            exp_q[i].delete();
        end
        pd_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic drain();
        pkt_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (gap_en) begin
            pkt_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        pkt_valid = 1'b1;
        data_in = b;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout busy=%0b required=0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [1:0] a, input int len, input bit bad);
        logic [7:0] pkt[$];
        logic [7:0] hdr, par, b;
        hdr = {6'(len), a};
        par = hdr;
        pkt.push_back(hdr);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            par ^= b;
            pkt.push_back(b);
        end
        pkt.push_back(bad ? ~par : par);
        if (a != 2'd3)
            for (int k = 0; k < pkt.size(); k++) exp_q[a].push_back({k == 0, pkt[k]});
        for (int k = 0; k < pkt.size(); k++) send_byte(pkt[k]);
        pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({write_enb, lfd_state, data_out, parity_done, err} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs got we=%b lfd=%b do=%h pd=%b err=%b required all 0", write_enb, lfd_state, data_out, parity_done, err);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_sb();
        send_packet(2'd1, 14, 0);
        drain();
        tests++;
        if (got_q[1].size() != 16) begin fails++; $display("FAIL basic_count got %0d required 16", got_q[1].size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL basic_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL basic_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
        tests++;
        if (pd_cnt != 1 || err !== 1'b0) begin fails++; $display("FAIL basic_parity pd=%0d err=%b required 1 0", pd_cnt, err); end
        tests++;
        if (busy_cnt != 0) begin fails++; $display("FAIL basic_busy got %0d required 0", busy_cnt); end
    endtask

    task automatic test_parity_err();
        clear_sb();
        send_packet(2'd1, 14, 1);
        tests++;
        if (parity_done !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL perr_flag pd=%b err=%b required 1 1", parity_done, err); end
        @(posedge clk);
        #1;
        tests++;
        if (err !== 1'b1 || parity_done !== 1'b0) begin fails++; $display("FAIL perr_hold err=%b pd=%b required 1 0", err, parity_done); end
        exp_q[0].push_back({1'b1, 8'h00});
        send_byte(8'h00);
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL perr_clear got %b required 0", err); end
        exp_q[0].push_back({1'b0, 8'h00});
        send_byte(8'h00);
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL perr_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL perr_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
        tests++;
        if (pd_cnt != 2 || err !== 1'b0) begin fails++; $display("FAIL perr_final pd=%0d err=%b required 2 0", pd_cnt, err); end
    endtask

    task automatic test_full_stall();
        clear_sb();
        fork
            send_packet(2'd1, 14, 0);
            begin
                int n = 0;
                logic [7:0] held;
                while (got_q[1].size() < 6 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                tests++;
                if (got_q[1].size() < 6) begin fails++; $display("FAIL stall_reach got %0d required 6", got_q[1].size()); end
                @(posedge clk);
                #1;
                fifo_full[1] = 1'b1;
                held = data_out;
                repeat (3) begin
                    @(negedge clk);
                    tests++;
                    if (busy !== 1'b1 || data_out !== held) begin fails++; $display("FAIL stall_hold busy=%b do=%h required 1 %h", busy, data_out, held); end
                end
                @(posedge clk);
                #1;
                fifo_full[1] = 1'b0;
            end
        join
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL stall_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL stall_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
    endtask

    task automatic test_empty_block();
        logic [7:0] pkt[$];
        logic [7:0] par, b;
        clear_sb();
        pkt.push_back({6'd3, 2'd2});
        par = pkt[0];
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            par ^= b;
            pkt.push_back(b);
        end
        pkt.push_back(par);
        for (int k = 0; k < pkt.size(); k++) exp_q[2].push_back({k == 0, pkt[k]});
        fifo_empty[2] = 1'b0;
        pkt_valid = 1'b1;
        data_in = pkt[0];
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b1 || write_enb !== 3'b000) begin fails++; $display("FAIL empty_block busy=%b we=%b required 1 000", busy, write_enb); end
        end
        @(posedge clk);
        #1;
        fifo_empty[2] = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL empty_release got %b required 0", busy); end
        @(posedge clk);
        #1;
        tests++;
        if (lfd_state !== 1'b1 || write_enb !== 3'b100) begin fails++; $display("FAIL empty_hdr lfd=%b we=%b required 1 100", lfd_state, write_enb); end
        for (int k = 1; k < pkt.size(); k++) send_byte(pkt[k]);
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL empty_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL empty_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
    endtask

    task automatic test_drop();
        clear_sb();
        send_packet(2'd3, 4, 0);
        send_packet(2'd0, $urandom_range(1, 20), 0);
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL drop_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL drop_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
        tests++;
        if (pd_cnt != 1) begin fails++; $display("FAIL drop_pd got %0d required 1", pd_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        send_byte({6'd10, 2'd0});
        repeat (4) send_byte(8'($urandom));
        pkt_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, write_enb, lfd_state, data_out, parity_done, err} !== 15'd0) begin
            fails++;
            $display("FAIL rstmid_outputs got busy=%b we=%b lfd=%b do=%h pd=%b err=%b required all 0", busy, write_enb, lfd_state, data_out, parity_done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_sb();
        send_packet(2'd2, 5, 0);
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL rstmid_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL rstmid_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
    endtask

    task automatic test_random();
        int exp_pd = 0;
        bit exp_err = 0;
        clear_sb();
        gap_en = 1;
        run = 1;
        fork
            begin
                for (int p = 0; p < 10; p++) begin
                    logic [1:0] a;
                    bit bad;
                    a = 2'($urandom_range(0, 3));
                    bad = 1'($urandom_range(0, 1));
                    send_packet(a, $urandom_range(0, 12), bad);
                    exp_pd += (a != 2'd3);
                    exp_err = (a != 2'd3) && bad;
                end
                run = 0;
            end
            while (run) begin
                @(posedge clk);
                #1;
                fifo_full = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            end
        join
        fifo_full = '0;
        gap_en = 0;
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q[i].size() != exp_q[i].size()) begin fails++; $display("FAIL rand_size[%0d] got %0d required %0d", i, got_q[i].size(), exp_q[i].size()); end
            else for (int k = 0; k < got_q[i].size(); k++) begin
                tests++;
                if (got_q[i][k] !== exp_q[i][k]) begin fails++; $display("FAIL rand_data[%0d][%0d] got %h required %h", i, k, got_q[i][k], exp_q[i][k]); end
            end
        end
        tests++;
        if (pd_cnt != exp_pd || err !== exp_err) begin fails++; $display("FAIL rand_parity pd=%0d err=%b required %0d %b", pd_cnt, err, exp_pd, exp_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_full_stall();
        test_empty_block();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
